fifo_wptr_full_gen: RTL and testbench

Parametrised write-side controller for the asynchronous FIFOs in the multi-clock subsystem. Runs entirely in the write clock domain and owns the binary and Gray write pointers, the write address and the memory write enable. Internally synchronises the read side's Gray pointer and derives full, almost-full, fill level and a sticky overflow flag. Works for any power-of-two depth, replacing fixed 16-entry Gray lookup logic with generic conversion.

---
 rtl/fifo_wptr_full_gen.sv | 83 ++++++++
 tb/tb_fifo_wptr_full_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full_gen.sv
// Write-side controller for a dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser, and full / almost-full / level / overflow flags.
module fifo_wptr_full_gen #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_LVL   = DEPTH - 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          W_CLK,
  input  logic          W_RST,
  input  logic          W_INC,
  input  logic [AW:0]   gray_Rptr,
  input  logic          W_OVF_CLR,
  output logic          W_EN,
  output logic [AW-1:0] Waddr,
  output logic [AW:0]   gray_Wptr,
  output logic          WFULL,
  output logic          WAFULL,
  output logic [AW:0]   W_LEVEL,
  output logic          W_OVF
);

  localparam logic [AW:0] AFULL_V = (AW+1)'(AFULL_LVL);

  logic [AW:0] wptr;
  logic [AW:0] wptr_next;
  logic [AW:0] rq_gray;
  logic [AW:0] rbin;
  logic [AW:0] sync_q [SYNC_STAGES];

  // W_INC is a request, W_EN its acceptance: a write takes effect on the edge
  // where W_INC=1 and WFULL=0; a request while full is dropped, never held.
  assign W_EN      = W_INC & ~WFULL;
  assign wptr_next = wptr + {{AW{1'b0}}, W_EN};

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wptr      <= '0;
      gray_Wptr <= '0;
    end else begin
      wptr      <= wptr_next;
      gray_Wptr <= wptr_next ^ (wptr_next >> 1);
    end
  end

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gray_Rptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    rbin = '0;
    for (int i = AW; i >= 0; i--) begin
      acc     = acc ^ rq_gray[i];
      rbin[i] = acc;
    end
  end

  assign Waddr   = wptr[AW-1:0];
  assign W_LEVEL = wptr - rbin;
  assign WFULL   = (wptr[AW] != rbin[AW]) && (wptr[AW-1:0] == rbin[AW-1:0]);
  assign WAFULL  = (W_LEVEL >= AFULL_V);

  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      W_OVF <= 1'b0;
    end else if (W_INC && WFULL) begin
      W_OVF <= 1'b1;
    end else if (W_OVF_CLR) begin
      W_OVF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full_gen.sv
// Bench for fifo_wptr_full_gen: 16-deep instance against a write/read-count
// model, plus a 64-deep, 3-stage instance for the fill and release timing.
module tb_fifo_wptr_full_gen;

  logic clk;
  logic rst;

  logic       i16, c16, en16, full16, afull16, ovf16;
  logic [4:0] r16, gw16, lvl16;
  logic [3:0] waddr16;

  logic       i64, c64, en64, full64, afull64, ovf64;
  logic [6:0] r64, gw64, lvl64;
  logic [5:0] waddr64;

  fifo_wptr_full_gen #(.DEPTH(16), .SYNC_STAGES(2), .AFULL_LVL(14)) dut16 (
    .W_CLK(clk), .W_RST(rst), .W_INC(i16), .gray_Rptr(r16), .W_OVF_CLR(c16),
    .W_EN(en16), .Waddr(waddr16), .gray_Wptr(gw16), .WFULL(full16),
    .WAFULL(afull16), .W_LEVEL(lvl16), .W_OVF(ovf16)
  );

  fifo_wptr_full_gen #(.DEPTH(64), .SYNC_STAGES(3), .AFULL_LVL(60)) dut64 (
    .W_CLK(clk), .W_RST(rst), .W_INC(i64), .gray_Rptr(r64), .W_OVF_CLR(c64),
    .W_EN(en64), .Waddr(waddr64), .gray_Wptr(gw64), .WFULL(full64),
    .WAFULL(afull64), .W_LEVEL(lvl64), .W_OVF(ovf64)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard counters
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // reference model: total writes accepted, total reads issued, and the read
  // totals as the write side sees them (one queue entry per synchroniser flop)
  int wr_total;
  int rd_total;
  int m_ovf;
  int vis_q[$];

  task automatic model_reset();
    wr_total = 0;
    rd_total = 0;
    m_ovf    = 0;
    vis_q.delete();
    vis_q.push_back(0);
    vis_q.push_back(0);
  endtask

  function automatic logic [4:0] g5(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  // driver: one clock cycle on dut16, checked before and after the edge
  task automatic cyc(input bit inc, input bit clr, input bit rd);
    int lvl;
    bit acc;
    logic [4:0] g_prev;
    if (rd) begin
      rd_total++;
      r16 = g5(rd_total);
    end
    i16 = inc;
    c16 = clr;
    #1;
    lvl = wr_total - vis_q[0];
    acc = inc && (lvl < 16);
    chk("w_en", en16, acc);
    chk("waddr_pre", waddr16, wr_total % 16);
    g_prev = gw16;
    @(posedge clk);
    if (inc && lvl == 16) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (acc) wr_total++;
    vis_q.push_back(rd_total);
    void'(vis_q.pop_front());
    #1;
    lvl = wr_total - vis_q[0];
    chk("w_level", lvl16, lvl);
    chk("wfull", full16, lvl == 16);
    chk("wafull", afull16, lvl >= 14);
    chk("w_ovf", ovf16, m_ovf);
    chk("waddr", waddr16, wr_total % 16);
    chk("gray_wptr", gw16, g5(wr_total));
    chk("gray_one_bit", $countones(g_prev ^ gw16), acc ? 1 : 0);
  endtask

  typedef struct {
    bit inc;
    bit clr;
    bit rd;
    bit exp_en;
    int exp_level;
    bit exp_full;
    bit exp_ovf;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int writes;
    int budget;
    tbl[0] = '{1, 0, 0, 0, 16, 1, 1};
    tbl[1] = '{1, 0, 0, 0, 16, 1, 1};
    tbl[2] = '{1, 0, 0, 0, 16, 1, 1};
    tbl[3] = '{0, 0, 0, 0, 16, 1, 1};
    tbl[4] = '{1, 1, 0, 0, 16, 1, 1};
    tbl[5] = '{0, 1, 0, 0, 16, 1, 0};
    tbl[6] = '{0, 0, 1, 0, 16, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 15, 0, 0};
    tbl[8] = '{1, 0, 0, 1, 16, 1, 0};

    rst = 1'b0;
    i16 = 0; c16 = 0; r16 = '0;
    i64 = 0; c64 = 0; r64 = '0;
    model_reset();

    // reset state before any clock edge
    #2;
    chk("rst_waddr", waddr16, 0);
    chk("rst_gray", gw16, 0);
    chk("rst_level", lvl16, 0);
    chk("rst_full", full16, 0);
    chk("rst_afull", afull16, 0);
    chk("rst_ovf", ovf16, 0);
    chk("rst_level64", lvl64, 0);
    chk("rst_full64", full64, 0);
    i16 = 1;
    #1;
    chk("rst_en_follows_inc", en16, 1);
    i16 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // fill 16 entries
    for (int i = 0; i < 16; i++) cyc(1, 0, 0);
    chk("fill_gray_11000", gw16, 5'b11000);
    chk("fill_full", full16, 1);

    // overflow, clear priority, read release, write after release
    for (int i = 0; i < 9; i++) begin
      i16 = tbl[i].inc;
      #1;
      chk("tbl_en", en16, tbl[i].exp_en);
      cyc(tbl[i].inc, tbl[i].clr, tbl[i].rd);
      chk("tbl_level", lvl16, tbl[i].exp_level);
      chk("tbl_full", full16, tbl[i].exp_full);
      chk("tbl_ovf", ovf16, tbl[i].exp_ovf);
    end

    // drain, then random traffic with level <= 8 until 40 more writes
    while (rd_total < wr_total) cyc(0, 0, 1);
    writes = 0;
    budget = 0;
    while (writes < 40 && budget < 400) begin
      bit inc;
      bit rd;
      inc = ($urandom_range(0, 3) != 0) && ((wr_total - vis_q[0]) < 8);
      rd  = ($urandom_range(0, 1) == 1) && (rd_total < wr_total);
      if (inc) writes++;
      cyc(inc, $urandom_range(0, 7) == 0, rd);
      budget++;
    end
    chk("wrap_budget", budget < 400, 1);
    chk("wrap_passed", wr_total > 32, 1);

    // async reset at level 10, no clock edge while low
    while (rd_total < wr_total) cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    chk("pre_rst_level", lvl16, 10);
    i16 = 1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_waddr", waddr16, 0);
    chk("arst_gray", gw16, 0);
    chk("arst_level", lvl16, 0);
    chk("arst_full", full16, 0);
    chk("arst_afull", afull16, 0);
    chk("arst_ovf", ovf16, 0);
    chk("arst_en", en16, 1);
    r16 = '0;
    #3;
    rst = 1'b1;
    model_reset();
    cyc(1, 0, 0);
    chk("first_write_after_rst", wr_total, 1);

    // 64-deep instance: fill, almost-full at 60, release seen after 3 edges
    i16 = 0;
    c16 = 0;
    for (int i = 0; i < 64; i++) begin
      i64 = 1;
      #1;
      chk("d64_en", en64, 1);
      chk("d64_waddr", waddr64, i);
      @(posedge clk);
      #1;
      chk("d64_level", lvl64, i + 1);
      chk("d64_afull", afull64, (i + 1) >= 60);
      chk("d64_full", full64, (i + 1) == 64);
    end
    i64 = 1;
    #1;
    chk("d64_en_full", en64, 0);
    i64 = 0;
    r64 = 7'b0000001;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      chk("d64_release_full", full64, e < 3);
      chk("d64_release_level", lvl64, e < 3 ? 64 : 63);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
